// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold-bus width and hold level codes.
package pipe_ctrl_pkg;

    localparam int unsigned HOLD_FLAG_BUS_W = 3;

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ID   = 3'b011;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: redirect muxing, hold-level arbitration, debug halt
// sequencing and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_W      = HOLD_FLAG_BUS_W,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_ex_i,
    input  logic              div_busy_i,
    input  logic              rib_hold_flag_i,
    input  logic              jtag_halt_flag_i,
    input  logic              clint_hold_flag_i,
    input  logic              clint_int_assert_i,
    input  logic [ADDR_W-1:0] clint_int_addr_i,
    output logic [HOLD_W-1:0] hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              halted_o,
    output logic [31:0]       stall_cnt_o
);

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_FLUSH  = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_HALT   = 3'd3;
    localparam logic [2:0] ST_RESUME = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   core_idle;

    always_comb begin
        jump_flag_o = jump_flag_i | clint_int_assert_i;
        if (clint_int_assert_i)
            jump_addr_o = clint_int_addr_i;
        else if (jump_flag_i)
            jump_addr_o = jump_addr_i;
        else
            jump_addr_o = '0;
    end

    always_comb begin
        if (jump_flag_o || hold_flag_ex_i || clint_hold_flag_i || state == ST_HALT)
            hold_flag_o = HOLD_W'(HOLD_ID);
        else if (state == ST_FLUSH || state == ST_RESUME)
            hold_flag_o = HOLD_W'(HOLD_IF);
        else if (rib_hold_flag_i || state == ST_DRAIN)
            hold_flag_o = HOLD_W'(HOLD_PC);
        else
            hold_flag_o = HOLD_W'(HOLD_NONE);
    end

    // Halt is only granted once nothing is in flight; a jump seen while
    // draining is flushed through hold_flag_o without leaving DRAIN.
    assign core_idle = !div_busy_i && !rib_hold_flag_i && !hold_flag_ex_i && !jump_flag_o;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (jump_flag_o)
                    state_nxt = ST_FLUSH;
                else if (jtag_halt_flag_i)
                    state_nxt = ST_DRAIN;
            end
            ST_FLUSH:
                state_nxt = jtag_halt_flag_i ? ST_DRAIN : ST_RUN;
            ST_DRAIN: begin
                if (!jtag_halt_flag_i)
                    state_nxt = ST_RUN;
                else if (core_idle)
                    state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (!jtag_halt_flag_i)
                    state_nxt = ST_RESUME;
            end
            ST_RESUME:
                state_nxt = ST_RUN;
            default:
                state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (hold_flag_o != HOLD_W'(HOLD_NONE) && state != ST_HALT && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign halted_o    = (state == ST_HALT);
    assign stall_cnt_o = 32'(stall_cnt);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reset/combinational vector table,
// directed halt/jump/reset sequences and randomized traffic against a model.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        div_busy_i;
    logic        rib_hold_flag_i;
    logic        jtag_halt_flag_i;
    logic        clint_hold_flag_i;
    logic        clint_int_assert_i;
    logic [31:0] clint_int_addr_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halted_o;
    logic [31:0] stall_cnt_o;
    logic [2:0]  s_hold;
    logic        s_jf;
    logic [31:0] s_ja;
    logic        s_halted;
    logic [31:0] s_cnt;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.HOLD_W(3), .ADDR_W(32), .STALL_CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_ex_i(hold_flag_ex_i), .div_busy_i(div_busy_i),
        .rib_hold_flag_i(rib_hold_flag_i), .jtag_halt_flag_i(jtag_halt_flag_i),
        .clint_hold_flag_i(clint_hold_flag_i), .clint_int_assert_i(clint_int_assert_i),
        .clint_int_addr_i(clint_int_addr_i),
        .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .halted_o(halted_o), .stall_cnt_o(stall_cnt_o)
    );

    // Narrow-counter instance makes the saturation point reachable in simulation.
    pipe_ctrl #(.HOLD_W(3), .ADDR_W(32), .STALL_CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_ex_i(hold_flag_ex_i), .div_busy_i(div_busy_i),
        .rib_hold_flag_i(rib_hold_flag_i), .jtag_halt_flag_i(jtag_halt_flag_i),
        .clint_hold_flag_i(clint_hold_flag_i), .clint_int_assert_i(clint_int_assert_i),
        .clint_int_addr_i(clint_int_addr_i),
        .hold_flag_o(s_hold), .jump_flag_o(s_jf), .jump_addr_o(s_ja),
        .halted_o(s_halted), .stall_cnt_o(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: debug-halt phase plus stall counts as plain integers.
    typedef enum {P_RUN, P_FLUSH, P_DRAIN, P_HALT, P_RESUME} phase_t;
    phase_t  m_phase;
    longint  m_cnt;
    longint  m_cnt_sat;

    function automatic logic m_jump();
        return jump_flag_i || clint_int_assert_i;
    endfunction

    function automatic logic [31:0] m_addr();
        if (clint_int_assert_i) return clint_int_addr_i;
        if (jump_flag_i)        return jump_addr_i;
        return 32'd0;
    endfunction

    function automatic int m_hold();
        if (m_jump() || hold_flag_ex_i || clint_hold_flag_i || m_phase == P_HALT) return 3;
        if (m_phase == P_FLUSH || m_phase == P_RESUME) return 2;
        if (rib_hold_flag_i || m_phase == P_DRAIN) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".hold"},   32'(hold_flag_o), 32'(m_hold()));
        chk({tag, ".jflag"},  32'(jump_flag_o), 32'(m_jump()));
        chk({tag, ".jaddr"},  jump_addr_o, m_addr());
        chk({tag, ".halted"}, 32'(halted_o), 32'(m_phase == P_HALT));
        chk({tag, ".cnt"},    stall_cnt_o, 32'(m_cnt));
        chk({tag, ".cnt4"},   s_cnt, 32'(m_cnt_sat));
    endtask

    task automatic model_reset();
        m_phase   = P_RUN;
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    // One clock: the model advances on the inputs present at the edge.
    task automatic tick();
        phase_t nxt;
        logic   counts;
        nxt = m_phase;
        counts = (m_hold() != 0) && (m_phase != P_HALT);
        unique case (m_phase)
            P_RUN:    if (m_jump()) nxt = P_FLUSH; else if (jtag_halt_flag_i) nxt = P_DRAIN;
            P_FLUSH:  nxt = jtag_halt_flag_i ? P_DRAIN : P_RUN;
            P_DRAIN:  if (!jtag_halt_flag_i) nxt = P_RUN;
                      else if (!(div_busy_i || rib_hold_flag_i || hold_flag_ex_i || m_jump())) nxt = P_HALT;
            P_HALT:   if (!jtag_halt_flag_i) nxt = P_RESUME;
            P_RESUME: nxt = P_RUN;
        endcase
        @(posedge clk);
        #1;
        if (rst) begin
            m_phase = nxt;
            if (counts) begin
                m_cnt     = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
                m_cnt_sat = (m_cnt_sat < 15) ? m_cnt_sat + 1 : m_cnt_sat;
            end
        end
    endtask

    task automatic clear_inputs();
        jump_flag_i = 0; jump_addr_i = 0; hold_flag_ex_i = 0; div_busy_i = 0;
        rib_hold_flag_i = 0; jtag_halt_flag_i = 0; clint_hold_flag_i = 0;
        clint_int_assert_i = 0; clint_int_addr_i = 0;
    endtask

    typedef struct {
        logic        jf;
        logic [31:0] ja;
        logic        ia;
        logic [31:0] iad;
        logic        hex;
        logic        ch;
        logic        rib;
        logic        e_jf;
        logic [31:0] e_ja;
        logic [2:0]  e_hold;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{0, 32'h0,    0, 32'h0,  0, 0, 0, 0, 32'h0,   3'd0};
        vt[1] = '{1, 32'h100,  0, 32'h0,  0, 0, 0, 1, 32'h100, 3'd3};
        vt[2] = '{1, 32'h100,  1, 32'h80, 0, 0, 0, 1, 32'h80,  3'd3};
        vt[3] = '{0, 32'h100,  1, 32'h80, 0, 0, 0, 1, 32'h80,  3'd3};
        vt[4] = '{0, 32'h1234, 0, 32'h0,  0, 0, 0, 0, 32'h0,   3'd0};
        vt[5] = '{0, 32'h0,    0, 32'h0,  1, 0, 0, 0, 32'h0,   3'd3};
        vt[6] = '{0, 32'h0,    0, 32'h0,  0, 1, 0, 0, 32'h0,   3'd3};
        vt[7] = '{0, 32'h0,    0, 32'h0,  0, 0, 1, 0, 32'h0,   3'd1};
        vt[8] = '{0, 32'h0,    0, 32'h0,  1, 0, 1, 0, 32'h0,   3'd3};

        rst = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        chk("rst.hold",   32'(hold_flag_o), 32'd0);
        chk("rst.jflag",  32'(jump_flag_o), 32'd0);
        chk("rst.jaddr",  jump_addr_o, 32'd0);
        chk("rst.halted", 32'(halted_o), 32'd0);
        chk("rst.cnt",    stall_cnt_o, 32'd0);

        // Combinational vectors while held in reset (state pinned to RUN).
        for (int unsigned i = 0; i < 9; i++) begin
            jump_flag_i = vt[i].jf;  jump_addr_i = vt[i].ja;
            clint_int_assert_i = vt[i].ia; clint_int_addr_i = vt[i].iad;
            hold_flag_ex_i = vt[i].hex; clint_hold_flag_i = vt[i].ch;
            rib_hold_flag_i = vt[i].rib;
            #1;
            chk($sformatf("vec%0d.jflag", i), 32'(jump_flag_o), 32'(vt[i].e_jf));
            chk($sformatf("vec%0d.jaddr", i), jump_addr_o, vt[i].e_ja);
            chk($sformatf("vec%0d.hold", i),  32'(hold_flag_o), 32'(vt[i].e_hold));
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Stall count from reset: ten bus-stall cycles.
        rib_hold_flag_i = 1;
        for (int unsigned i = 0; i < 10; i++) begin
            check_all("rib");
            chk("rib.hold1", 32'(hold_flag_o), 32'd1);
            tick();
        end
        chk("rib.cnt10", stall_cnt_o, 32'd10);
        for (int unsigned i = 0; i < 8; i++) tick();
        check_all("sat");
        chk("sat.cnt4", s_cnt, 32'd15);
        rib_hold_flag_i = 0;
        tick();

        // Jump: flush bubble for one cycle, then free running.
        jump_flag_i = 1; jump_addr_i = 32'h100;
        check_all("jmp0");
        chk("jmp0.hold3", 32'(hold_flag_o), 32'd3);
        chk("jmp0.addr", jump_addr_o, 32'h100);
        tick();
        jump_flag_i = 0; jump_addr_i = 0;
        check_all("jmp1");
        chk("jmp1.hold2", 32'(hold_flag_o), 32'd2);
        tick();
        check_all("jmp2");
        chk("jmp2.hold0", 32'(hold_flag_o), 32'd0);

        // Debug halt while the divider is busy.
        jtag_halt_flag_i = 1; div_busy_i = 1;
        check_all("dh0");
        tick();
        for (int unsigned i = 0; i < 5; i++) begin
            check_all("drain");
            chk("drain.hold1", 32'(hold_flag_o), 32'd1);
            chk("drain.nohalt", 32'(halted_o), 32'd0);
            tick();
        end
        div_busy_i = 0;
        check_all("drain.last");
        tick();
        check_all("halt");
        chk("halt.halted", 32'(halted_o), 32'd1);
        chk("halt.hold3", 32'(hold_flag_o), 32'd3);
        tick();
        check_all("halt2");
        jtag_halt_flag_i = 0;
        tick();
        check_all("resume");
        chk("resume.hold2", 32'(hold_flag_o), 32'd2);
        tick();
        check_all("run");
        chk("run.hold0", 32'(hold_flag_o), 32'd0);

        // Jump arriving during DRAIN is flushed but the halt request persists.
        jtag_halt_flag_i = 1;
        tick();
        jump_flag_i = 1; jump_addr_i = 32'h200;
        check_all("djmp");
        tick();
        jump_flag_i = 0; jump_addr_i = 0;
        check_all("djmp1");
        chk("djmp1.hold1", 32'(hold_flag_o), 32'd1);
        tick();
        check_all("djmp2");
        chk("djmp2.halted", 32'(halted_o), 32'd1);

        // Asynchronous reset while halted.
        #2;
        rst = 1'b0;
        #1;
        chk("arst.halted", 32'(halted_o), 32'd0);
        chk("arst.cnt", stall_cnt_o, 32'd0);
        model_reset();
        jtag_halt_flag_i = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_all("arst.run");
        chk("arst.hold0", 32'(hold_flag_o), 32'd0);

        // Randomized traffic; the halt request is sticky to reach deep states.
        for (int unsigned i = 0; i < 3000; i++) begin
            jump_flag_i        = ($urandom_range(0, 7) == 0);
            jump_addr_i        = $urandom;
            clint_int_assert_i = ($urandom_range(0, 15) == 0);
            clint_int_addr_i   = $urandom;
            hold_flag_ex_i     = ($urandom_range(0, 9) == 0);
            div_busy_i         = ($urandom_range(0, 3) == 0);
            rib_hold_flag_i    = ($urandom_range(0, 5) == 0);
            clint_hold_flag_i  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) jtag_halt_flag_i = ~jtag_halt_flag_i;
            check_all("rand");
            if ($urandom_range(0, 299) == 0) begin
                #1;
                rst = 1'b0;
                #1;
                chk("rand.arst.cnt", stall_cnt_o, 32'd0);
                chk("rand.arst.halted", 32'(halted_o), 32'd0);
                model_reset();
                rst = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
